// File: rtl/if_mem_responder.sv
// Instruction-fetch memory responder: gathers four bytes from a byte-wide sync RAM into a little-endian word.
// Define IF_PREFETCH_EN to enable speculative sequential prefetch of the next word after each completion.
module if_mem_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_read,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic                  if_busy,
   output logic                  if_ready,
   output logic [ADDR_WIDTH-1:0] if_ready_addr,
   output logic [31:0]           if_data,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_a,
   input  logic [7:0]            mem_din
);

`ifdef IF_PREFETCH_EN
   localparam logic PF_EN = 1'b1;
`else
   localparam logic PF_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                        r_state, w_state_n;
   logic [1:0]                    r_k, w_k_n;
   logic [ADDR_WIDTH-1:0]         r_base;
   logic                          r_busy, r_ready, r_spec;
   logic [ADDR_WIDTH-1:0]         r_ready_addr;
   logic [31:0]                   r_data;
   logic [23:0]                   r_word;
   logic [RAM_LATENCY-1:0]        r_cap_vld;
   logic [RAM_LATENCY-1:0][1:0]   r_cap_k;

   logic w_pf_act, w_merge, w_accept, w_done, w_pf_start;

   // A running prefetch is not "busy", so a matching request merges instead of restarting.
   assign w_pf_act   = PF_EN && r_spec && (r_state != S_IDLE);
   assign w_merge    = w_pf_act && if_read && !if_flush && (if_addr == r_base);
   assign w_accept   = if_read && !r_busy && !if_flush && !w_merge;
   assign w_done     = (r_state == S_DRAIN) && !if_flush;
   assign w_pf_start = PF_EN && w_done && !w_accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= 2'd0;
      end else begin
         r_state <= w_state_n;
         r_k     <= w_k_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_k_n     = r_k;
      mem_rd    = 1'b0;
      mem_a     = '0;
      if (if_flush) begin
         w_state_n = S_IDLE;
         w_k_n     = 2'd0;
      end else if (w_accept) begin
         w_state_n = S_ISSUE;
         w_k_n     = 2'd0;
      end else begin
         case (r_state)
            S_ISSUE: begin
               if (r_k == 2'd3) begin
                  w_state_n = S_DRAIN;
                  w_k_n     = 2'd0;
               end else begin
                  w_k_n = r_k + 2'd1;
               end
            end
            S_DRAIN: begin
               w_state_n = w_pf_start ? S_ISSUE : S_IDLE;
               w_k_n     = 2'd0;
            end
            default: w_state_n = S_IDLE;
         endcase
      end
      if (r_state == S_ISSUE) begin
         mem_rd = 1'b1;
         mem_a  = r_base + ADDR_WIDTH'(r_k);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_base       <= '0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b0;
         r_spec       <= 1'b0;
         r_ready_addr <= '0;
         r_data       <= '0;
         r_word       <= '0;
         r_cap_vld    <= '0;
         r_cap_k      <= '0;
      end else begin
         // Byte-capture pipeline trails address issue by the RAM latency.
         r_cap_vld[0] <= (r_state == S_ISSUE);
         r_cap_k[0]   <= r_k;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            r_cap_vld[i] <= r_cap_vld[i-1];
            r_cap_k[i]   <= r_cap_k[i-1];
         end
         if (r_cap_vld[RAM_LATENCY-1]) begin
            case (r_cap_k[RAM_LATENCY-1])
               2'd0:    r_word[7:0]   <= mem_din;
               2'd1:    r_word[15:8]  <= mem_din;
               2'd2:    r_word[23:16] <= mem_din;
               default: ;
            endcase
         end

         if (if_flush) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_spec  <= 1'b0;
         end else if (w_accept) begin
            r_base  <= if_addr;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_spec  <= 1'b0;
         end else if (w_done) begin
            // Last byte goes straight from the RAM into the result word.
            r_data       <= {mem_din, r_word};
            r_ready_addr <= r_base;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_spec       <= PF_EN;
            if (PF_EN) r_base <= r_base + ADDR_WIDTH'(4);
         end else if (w_merge) begin
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_spec  <= 1'b0;
         end
      end
   end

   assign if_busy       = r_busy;
   assign if_ready      = r_ready;
   assign if_ready_addr = r_ready_addr;
   assign if_data       = r_data;

endmodule

// File: tb/tb_if_mem_responder.sv
// Directed + randomized bench for if_mem_responder (default build, no prefetch).
module tb_if_mem_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_read = 1'b0;
   logic        if_flush = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_busy, if_ready, mem_rd;
   logic [31:0] if_ready_addr, if_data, mem_a;
   logic [7:0]  mem_din = 8'd0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   if_mem_responder #(.ADDR_WIDTH(32), .RAM_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .if_read(if_read), .if_addr(if_addr), .if_flush(if_flush),
      .if_busy(if_busy), .if_ready(if_ready), .if_ready_addr(if_ready_addr), .if_data(if_data),
      .mem_rd(mem_rd), .mem_a(mem_a), .mem_din(mem_din)
   );

   // Sparse RAM: contents are random on first touch and fixed afterwards.
   logic [7:0] ram [logic [31:0]];

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (!ram.exists(a)) ram[a] = 8'($urandom);
      return ram[a];
   endfunction

   function automatic logic [31:0] word(input logic [31:0] a);
      return {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
   endfunction

   always @(posedge clk) if (mem_rd) mem_din <= rd(mem_a);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(if_busy), 32'd0);
      chk({tag, "_ready"}, 32'(if_ready), 32'd0);
      chk({tag, "_raddr"}, if_ready_addr, 32'd0);
      chk({tag, "_data"}, if_data, 32'd0);
      chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
      chk({tag, "_mem_a"}, mem_a, 32'd0);
   endtask

   // One request at a; optionally a second if_read (poke_a) driven during cycle poke_cyc, which must be ignored.
   task automatic fetch(input logic [31:0] a, input int poke_cyc, input logic [31:0] poke_a);
      logic [31:0] exp_w;
      if_read = 1'b1;
      if_addr = a;
      cyc();
      if_read = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         chk("busy", 32'(if_busy), 32'd1);
         chk("ready_lo", 32'(if_ready), 32'd0);
         chk("mem_rd", 32'(mem_rd), (c <= 4) ? 32'd1 : 32'd0);
         chk("mem_a", mem_a, (c <= 4) ? a + 32'(c - 1) : 32'd0);
         if (c == poke_cyc) begin
            if_read = 1'b1;
            if_addr = poke_a;
         end else begin
            if_read = 1'b0;
         end
         cyc();
      end
      if_read = 1'b0;
      exp_w = word(a);
      chk("done_ready", 32'(if_ready), 32'd1);
      chk("done_busy", 32'(if_busy), 32'd0);
      chk("done_addr", if_ready_addr, a);
      chk("done_data", if_data, exp_w);
      chk("done_mem_rd", 32'(mem_rd), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, pa, w40;
      int          pc, gap;

      // Reset state
      cyc();
      cyc();
      chk_zero("rst");
      reset = 1'b0;
      cyc();

      // Basic fetch
      ram[32'h100] = 8'h13;
      ram[32'h101] = 8'h05;
      ram[32'h102] = 8'h00;
      ram[32'h103] = 8'h00;
      fetch(32'h100, 0, 32'h0);
      chk("basic_word", if_data, 32'h0000_0513);

      // Hold for 10 idle cycles
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("hold_ready", 32'(if_ready), 32'd1);
         chk("hold_addr", if_ready_addr, 32'h100);
         chk("hold_data", if_data, 32'h0000_0513);
         chk("hold_busy", 32'(if_busy), 32'd0);
         chk("hold_mem_rd", 32'(mem_rd), 32'd0);
      end

      // Back-to-back, then busy-ignore, then repeat of same address
      fetch(32'h104, 0, 32'h0);
      fetch(32'h100, 3, 32'h200);
      chk("ignore_word", if_data, 32'h0000_0513);
      fetch(32'h100, 5, 32'h100);

      // Flush in cycle 3 of a fetch
      if_read = 1'b1;
      if_addr = 32'h180;
      cyc();
      if_read = 1'b0;
      cyc();
      cyc();
      if_flush = 1'b1;
      cyc();
      if_flush = 1'b0;
      chk("flush_busy", 32'(if_busy), 32'd0);
      chk("flush_ready", 32'(if_ready), 32'd0);
      chk("flush_mem_rd", 32'(mem_rd), 32'd0);
      cyc();
      chk("flush_no_ready", 32'(if_ready), 32'd0);
      chk("flush_idle_rd", 32'(mem_rd), 32'd0);
      fetch(32'h40, 0, 32'h0);
      w40 = word(32'h40);

      // Flush in IDLE with a simultaneous read: ready clears, read ignored, word kept
      if_flush = 1'b1;
      if_read  = 1'b1;
      if_addr  = 32'h500;
      cyc();
      if_flush = 1'b0;
      if_read  = 1'b0;
      chk("iflush_ready", 32'(if_ready), 32'd0);
      chk("iflush_busy", 32'(if_busy), 32'd0);
      chk("iflush_mem_rd", 32'(mem_rd), 32'd0);
      chk("iflush_addr", if_ready_addr, 32'h40);
      chk("iflush_data", if_data, w40);

      // Address wrap
      fetch(32'hFFFF_FFFE, 0, 32'h0);

      // Reset in cycle 2 of a fetch
      if_read = 1'b1;
      if_addr = 32'h300;
      cyc();
      if_read = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      chk_zero("mrst");
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("mrst_no_ready", 32'(if_ready), 32'd0);
         chk("mrst_no_busy", 32'(if_busy), 32'd0);
      end

      // Randomized fetches with ignored pokes and idle gaps
      for (int i = 0; i < 24; i++) begin
         ra  = $urandom;
         if (i % 4 == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         pa  = $urandom;
         pc  = $urandom_range(0, 5);
         gap = $urandom_range(0, 3);
         fetch(ra, pc, pa);
         for (int g = 0; g < gap; g++) begin
            cyc();
            chk("rnd_hold_addr", if_ready_addr, ra);
            chk("rnd_hold_ready", 32'(if_ready), 32'd1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/if_mem_responder.md
Name: if_mem_responder

Overview:
- Memory-side responder for the instruction-fetch request port; the fetch stage's partner on that interface.
- Accepts a 32-bit fetch request (read strobe plus byte address) and reads four consecutive bytes from byte-wide synchronous RAM.
- Returns a little-endian instruction word with the address it belongs to, and holds it until the next accepted request.
- Reports busy while a fetch is in flight, so the fetch stage re-issues or holds its request.

Parameters:
ADDR_WIDTH, 32, byte address width of the request port and RAM address bus
RAM_LATENCY, 1, RAM read latency in cycles (address cycle to data cycle); only value 1 is supported

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  reset, synchronous, active-high
if_read  input  1  fetch request strobe, sampled at posedge
if_addr  input  ADDR_WIDTH  fetch byte address, valid with if_read
if_flush  input  1  abort in-flight fetch (branch redirect)
if_busy  output  1  registered; high while a fetch is in flight
if_ready  output  1  registered; if_data/if_ready_addr hold a completed word
if_ready_addr  output  ADDR_WIDTH  address of the word in if_data
if_data  output  32  fetched instruction, byte at if_ready_addr in bits [7:0]
mem_rd  output  1  RAM read enable
mem_a  output  ADDR_WIDTH  RAM byte address
mem_din  input  8  RAM read data, valid one cycle after its address

Behaviour:
- Reset (synchronous, active-high): all outputs become 0 at the edge where reset is sampled high; FSM goes to IDLE; any in-flight fetch is discarded and no ready is produced for it.
- Accept rule: a request is accepted at edge E0 when if_read=1, if_busy=0, if_flush=0 and reset=0.
- On accept:
  - latch base address A;
  - if_ready goes to 0 and if_busy to 1 after E0;
  - if_ready_addr and if_data keep their old values but are invalid.
- FSM states:
  - IDLE -> ISSUE on accept.
  - ISSUE (byte counter k=0..3): mem_rd=1, mem_a=A+k. Cycles 1..4 after E0 present A, A+1, A+2, A+3.
  - DRAIN: one cycle to capture the last byte; mem_rd=0.
  - DRAIN -> IDLE at E5.
- Data capture:
  - the byte for address A+k is captured from mem_din at edge E(k+2) into data[8k+7:8k];
  - the capture pipeline runs alongside ISSUE, so capture overlaps address issue.
- Completion at E5:
  - if_data = {b3,b2,b1,b0}, if_ready_addr = A;
  - if_ready=1 and if_busy=0, both visible in the cycle after E5;
  - latency from accept edge to if_ready visible is 5 cycles.
- Hold: if_ready, if_ready_addr and if_data remain stable in IDLE until the next accept or flush. A repeated if_read for the same A while ready is a legal new request and refetches.
- Address arithmetic: A+k wraps modulo 2^ADDR_WIDTH (e.g. A=0xFFFFFFFE reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1). No alignment check is made.
- mem_a and mem_rd are 0 in IDLE and DRAIN.
- if_flush:
  - sampled high while busy: fetch aborts; after that edge if_busy=0, if_ready=0, mem_rd=0, FSM returns to IDLE.
  - if_read in the same cycle as if_flush is ignored; the requester re-issues next cycle.
  - in IDLE, if_flush clears if_ready only.
- Reset and if_flush together: reset wins (identical result).
- if_read while busy is ignored; no queueing.

Optional Feature:
- Macro: IF_PREFETCH_EN.
- Defined:
  - After a completion for A, with no accept at that edge, the block starts a speculative fetch of A+4 through the same ISSUE/DRAIN sequence.
  - if_busy stays 0 during the prefetch, and the ready word for A stays visible throughout.
  - If if_read arrives during the prefetch with if_addr == A+4: the request merges. The prefetch continues, if_busy goes to 1, and completion proceeds as normal.
  - If if_read arrives with any other address: the prefetch aborts and the new request is accepted at that edge with normal timing.
  - If the prefetch completes unrequested, if_ready_addr=A+4 and the data update; then the next prefetch (A+8) starts.
  - if_flush and reset abort any prefetch.
- Undefined: no speculative reads; mem_rd is high only for accepted requests.

Test Plan:
- Basic fetch: RAM[0x100..0x103]=13,05,00,00; if_read=1 and if_addr=0x100 for one cycle -> if_busy=1 for cycles 1-5; mem_a=0x100..0x103 in cycles 1-4; cycle 6: if_ready=1, if_ready_addr=0x100, if_data=0x00000513.
- Hold and back-to-back: after the above, keep if_read=0 for 10 cycles -> outputs stable; then request 0x104 -> if_ready drops after the accept edge, and the new word appears 5 cycles later.
- Busy ignore: second if_read with 0x200 during cycle 3 -> no effect; the result is for 0x100; mem_a never equals 0x200.
- Flush: if_flush in cycle 3 of a fetch -> next cycle if_busy=0, if_ready=0, mem_rd=0; a new request to 0x40 then completes normally with correct data.
- Wrap and reset: fetch at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1; reset asserted in cycle 2 of a fetch -> all outputs 0 and no if_ready afterwards.
- IF_PREFETCH_EN: fetch 0x100 then idle -> mem_a runs 0x104..0x107 with if_busy=0; request 0x104 mid-prefetch -> merges, ready with 0x104 at the original prefetch completion cycle; request 0x300 mid-prefetch -> accepted immediately, ready 5 cycles later.
